// File: rtl/uart_rx_frame_buffer.sv
// Byte FIFO behind a UART receiver that counts delimiter-terminated frames.
// Optional frame gating (hold output until a full frame is stored) via `define RX_FRAME_GATE_EN.
module uart_rx_frame_buffer #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  DELIM = 8'h0D
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     frame_cnt,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] frame_cnt_r;
    logic [LW-1:0] level_nxt_s;
    logic [LW-1:0] frame_cnt_nxt_s;
    logic          overflow_r;
    logic          full_s;
    logic          empty_s;
    logic          xfer_s;
    logic          wr_en_s;
    logic          drop_s;
    logic          in_delim_s;
    logic          head_delim_s;
    logic          out_valid_s;
    logic          out_last_s;

    assign out_data     = mem_r[rd_ptr_r];
    assign full_s       = (level_r == LVL_FULL);
    assign empty_s      = (level_r == LVL_ZERO);
    assign in_delim_s   = (in_data == DELIM);
    assign head_delim_s = (out_data == DELIM);
    assign xfer_s       = out_valid_s & out_ready;
    // A transfer in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign wr_en_s      = in_valid & (~full_s | xfer_s);
    assign drop_s       = in_valid & full_s & ~xfer_s;

    assign out_valid = out_valid_s;
    assign out_last  = out_last_s;
    assign level     = level_r;
    assign frame_cnt = frame_cnt_r;
    assign overflow  = overflow_r;

    // Next fill level and frame count from this cycle's write and transfer.
    always_comb begin
        level_nxt_s     = level_r;
        frame_cnt_nxt_s = frame_cnt_r;
        case ({wr_en_s, xfer_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
        case ({wr_en_s & in_delim_s, xfer_s & head_delim_s})
            2'b10:   frame_cnt_nxt_s = frame_cnt_r + LVL_ONE;
            2'b01:   frame_cnt_nxt_s = frame_cnt_r - LVL_ONE;
            default: frame_cnt_nxt_s = frame_cnt_r;
        endcase
    end

    // Pointers, counters and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= LVL_ZERO;
            frame_cnt_r <= LVL_ZERO;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (xfer_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            level_r     <= level_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_s)       overflow_r <= 1'b1;
            else if (clr_ovf) overflow_r <= 1'b0;
            else              overflow_r <= overflow_r;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= in_data;
    end

`ifdef RX_FRAME_GATE_EN
    typedef enum logic [1:0] {
        ST_GATE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Gating state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_GATE;
        else        state_r <= state_nxt_s;
    end

    // Next-state logic; DRAIN breaks the deadlock of a full, unterminated frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_GATE: begin
                if (frame_cnt_r != LVL_ZERO) state_nxt_s = ST_RELEASE;
                else if (full_s)             state_nxt_s = ST_DRAIN;
                else                         state_nxt_s = ST_GATE;
            end
            ST_RELEASE: begin
                if (xfer_s && head_delim_s && (frame_cnt_nxt_s == LVL_ZERO)) state_nxt_s = ST_GATE;
                else                                                          state_nxt_s = ST_RELEASE;
            end
            ST_DRAIN: begin
                if (xfer_s && (level_nxt_s == LVL_ZERO)) state_nxt_s = ST_GATE;
                else                                     state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_GATE;
        endcase
    end

    // Output decode for the gated mode.
    always_comb begin
        out_valid_s = 1'b0;
        out_last_s  = ~empty_s & head_delim_s;
        case (state_r)
            ST_GATE:    out_valid_s = 1'b0;
            ST_RELEASE: out_valid_s = ~empty_s;
            ST_DRAIN: begin
                out_valid_s = ~empty_s;
                out_last_s  = ~empty_s & (head_delim_s | (level_r == LVL_ONE));
            end
            default:    out_valid_s = 1'b0;
        endcase
    end
`else
    // Output decode for the plain FIFO mode.
    always_comb begin
        out_valid_s = ~empty_s;
        out_last_s  = ~empty_s & head_delim_s;
    end
`endif

endmodule
